// File: rtl/cmsdk_apb_timclken_gen_pkg.sv
// cmsdk_apb_timclken_gen_pkg: register word addresses (PADDR[11:2]), CTRL/STATUS bit positions, divider width default
package cmsdk_apb_timclken_gen_pkg;
  localparam int DIV_W_DEF = 16;
  localparam logic [9:0] A_CTRL = 10'h000;
  localparam logic [9:0] A_DIV1 = 10'h001;
  localparam logic [9:0] A_DIV2 = 10'h002;
  localparam logic [9:0] A_CNT1 = 10'h003;
  localparam logic [9:0] A_CNT2 = 10'h004;
  localparam logic [9:0] A_STAT = 10'h005;
  localparam int CTRL_EN1 = 0;
  localparam int CTRL_EN2 = 1;
  localparam int CTRL_SYNC = 2;
  localparam int STAT_PEND1 = 0;
  localparam int STAT_PEND2 = 1;
  typedef enum logic [2:0] {R_CTRL, R_DIV1, R_DIV2, R_CNT1, R_CNT2, R_STAT, R_NONE} reg_e;
  function automatic reg_e decode(input logic [9:0] a);
    return a == A_CTRL ? R_CTRL :
           a == A_DIV1 ? R_DIV1 :
           a == A_DIV2 ? R_DIV2 :
           a == A_CNT1 ? R_CNT1 :
           a == A_CNT2 ? R_CNT2 :
           a == A_STAT ? R_STAT : R_NONE;
  endfunction
endpackage

// File: rtl/cmsdk_apb_timclken_gen_ch.sv
// cmsdk_apb_timclken_gen_ch: one divider channel with shadowed reload and a registered enable pulse
module cmsdk_apb_timclken_gen_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             en_nxt,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] wdata,
  output logic             tick,
  output logic             pend,
  output logic [DIV_W-1:0] cnt,
  output logic [DIV_W-1:0] div
);
  localparam logic [DIV_W-1:0] one = DIV_W'(1);
  logic [DIV_W-1:0] act, nxt;
  // div always holds the last written value, so it doubles as the shadow
  assign nxt = pend ? div : act;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      act <= '0;
      div <= '0;
      cnt <= '0;
      pend <= 1'b0;
      tick <= 1'b0;
    end else begin
      if (div_wr) div <= wdata;
      if (sync) begin
        act <= nxt;
        cnt <= nxt;
        pend <= 1'b0;
        tick <= 1'b0;
      end else if (en_nxt && !en) begin
        cnt <= act;
        tick <= 1'b0;
      end else if (!en_nxt) begin
        tick <= 1'b0;
        if (div_wr && !en) begin
          act <= wdata;
          cnt <= wdata;
          pend <= 1'b0;
        end
      end else if (cnt == '0) begin
        tick <= 1'b1;
        act <= nxt;
        cnt <= nxt;
        pend <= div_wr;
      end else begin
        tick <= 1'b0;
        cnt <= cnt - one;
        if (div_wr) pend <= 1'b1;
      end
    end
endmodule

// File: rtl/cmsdk_apb_timclken_gen.sv
// cmsdk_apb_timclken_gen: APB-programmable pair of clock-enable dividers feeding a dual timer
module cmsdk_apb_timclken_gen
  import cmsdk_apb_timclken_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:2] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        TIMCLKEN1,
  output logic        TIMCLKEN2
);
  reg_e sel;
  logic wr, rd, ctrl_wr, sync, unused_wdata;
  logic [1:0] en, en_nxt, pend;
  logic [DIV_W-1:0] cnt1, cnt2, div1, div2;
  logic [31:0] rdata;
  assign sel = decode(PADDR);
  assign wr = PSEL & PWRITE & ~PENABLE;
  assign rd = PSEL & ~PWRITE & ~PENABLE;
  assign ctrl_wr = wr && sel == R_CTRL;
  assign en_nxt = ctrl_wr ? PWDATA[CTRL_EN2:CTRL_EN1] : en;
  assign sync = ctrl_wr & PWDATA[CTRL_SYNC];
  assign unused_wdata = ^PWDATA;
  always_comb
    rdata = sel == R_CTRL ? 32'(en) :
            sel == R_DIV1 ? 32'(div1) :
            sel == R_DIV2 ? 32'(div2) :
            sel == R_CNT1 ? 32'(cnt1) :
            sel == R_CNT2 ? 32'(cnt2) :
            sel == R_STAT ? 32'(pend) : '0;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      en <= '0;
      PRDATA <= '0;
    end else begin
      en <= en_nxt;
      PRDATA <= rd ? rdata : '0;
    end
  cmsdk_apb_timclken_gen_ch #(.DIV_W(DIV_W)) u_ch1 (
    .clk(PCLK), .rst(PRESET), .en(en[CTRL_EN1]), .en_nxt(en_nxt[CTRL_EN1]), .sync(sync),
    .div_wr(wr && sel == R_DIV1), .wdata(PWDATA[DIV_W-1:0]),
    .tick(TIMCLKEN1), .pend(pend[STAT_PEND1]), .cnt(cnt1), .div(div1)
  );
  cmsdk_apb_timclken_gen_ch #(.DIV_W(DIV_W)) u_ch2 (
    .clk(PCLK), .rst(PRESET), .en(en[CTRL_EN2]), .en_nxt(en_nxt[CTRL_EN2]), .sync(sync),
    .div_wr(wr && sel == R_DIV2), .wdata(PWDATA[DIV_W-1:0]),
    .tick(TIMCLKEN2), .pend(pend[STAT_PEND2]), .cnt(cnt2), .div(div2)
  );
endmodule

// File: tb/tb_cmsdk_apb_timclken_gen.sv
// tb_cmsdk_apb_timclken_gen: directed and random APB traffic against a time-based divider model
module tb_cmsdk_apb_timclken_gen;
  localparam logic [31:0] MASK = 32'h0000_FFFF;
  logic pclk = 0, prst = 1, psel = 0, penable = 0, pwrite = 0;
  logic [9:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata, d;
  logic tclk1, tclk2;
  int checks = 0, failures = 0, cyc = 0, k;
  bit men[2], mpend[2], mtick[2];
  int mlast[2], mact[2], mnext[2], mhold[2];
  logic [31:0] mrd;
  logic [11:0] offs[8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'hFFC};

  cmsdk_apb_timclken_gen dut (
    .PCLK(pclk), .PRESET(prst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .TIMCLKEN1(tclk1), .TIMCLKEN2(tclk2)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      men[c] = 0; mpend[c] = 0; mtick[c] = 0;
      mlast[c] = 0; mact[c] = 0; mnext[c] = 0; mhold[c] = 0;
    end
    mrd = '0;
  endtask

  // A running channel is described by the absolute edge of its next pulse
  function automatic int cnt_of(input int c);
    return men[c] ? mnext[c] - cyc : mhold[c];
  endfunction

  task automatic model_edge();
    logic wr, rd, cw, dw, en_new;
    int w, cur;
    if (prst) begin
      model_reset();
      return;
    end
    wr = psel && pwrite && !penable;
    rd = psel && !pwrite && !penable;
    cw = wr && paddr == 10'h000;
    w = int'(pwdata & MASK);
    mrd = '0;
    if (rd)
      case (paddr)
        10'h000: mrd = {30'b0, men[1], men[0]};
        10'h001: mrd = mlast[0];
        10'h002: mrd = mlast[1];
        10'h003: mrd = cnt_of(0);
        10'h004: mrd = cnt_of(1);
        10'h005: mrd = {30'b0, mpend[1], mpend[0]};
        default: mrd = '0;
      endcase
    for (int c = 0; c < 2; c++) begin
      cur = cnt_of(c);
      en_new = cw ? pwdata[c] : men[c];
      dw = wr && paddr == 10'(c + 1);
      if (cw && pwdata[2]) begin
        if (mpend[c]) mact[c] = mlast[c];
        mpend[c] = 0;
        mtick[c] = 0;
        if (en_new) mnext[c] = cyc + mact[c] + 1;
        else mhold[c] = mact[c];
      end else if (en_new && !men[c]) begin
        mtick[c] = 0;
        mnext[c] = cyc + mact[c] + 1;
      end else if (!en_new) begin
        mtick[c] = 0;
        if (men[c]) mhold[c] = cur;
        else if (dw) begin
          mact[c] = w;
          mhold[c] = w;
          mpend[c] = 0;
        end
      end else begin
        mtick[c] = (cyc == mnext[c]);
        if (mtick[c]) begin
          if (mpend[c]) begin
            mact[c] = mlast[c];
            mpend[c] = 0;
          end
          mnext[c] = cyc + mact[c] + 1;
        end
        if (dw) mpend[c] = 1;
      end
      if (dw) mlast[c] = w;
      men[c] = en_new;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge pclk);
    #1;
    cyc++;
    chk("tick1", {31'b0, tclk1}, {31'b0, mtick[0]});
    chk("tick2", {31'b0, tclk2}, {31'b0, mtick[1]});
    chk("prdata", prdata, mrd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apb_wr(input logic [11:0] off, input logic [31:0] data);
    psel = 1; penable = 0; pwrite = 1; paddr = off[11:2]; pwdata = data;
    step();
    penable = 1;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input logic [11:0] off, output logic [31:0] data);
    psel = 1; penable = 0; pwrite = 0; paddr = off[11:2];
    step();
    data = prdata;
    penable = 1;
    step();
    psel = 0; penable = 0;
  endtask

  initial begin
    model_reset();
    idle(2);
    prst = 0;
    chk("rst_prdata", prdata, 0);
    chk("rst_tick", {30'b0, tclk2, tclk1}, 0);
    apb_rd(12'h000, d); chk("rst_ctrl", d, 0);
    apb_rd(12'h004, d); chk("rst_div1", d, 0);
    // DIV1=3: first pulse on the 4th edge after the enabling edge, then every 4
    apb_wr(12'h004, 32'd3);
    apb_wr(12'h000, 32'h1);
    k = 0;
    while (!tclk1 && k < 12) begin step(); k++; end
    chk("first_pulse_edge", 1 + k, 4);
    k = 0;
    do begin step(); k++; end while (!tclk1 && k < 12);
    chk("period_div3", k, 4);
    // DIV2=0: continuous enable
    apb_wr(12'h008, 32'd0);
    apb_wr(12'h000, 32'h3);
    chk("tick2_on", {31'b0, tclk2}, 1);
    idle(3);
    apb_wr(12'h000, 32'h1);
    chk("tick2_off", {31'b0, tclk2}, 0);
    // shadowed divider change while running
    apb_wr(12'h000, 32'h0);
    apb_wr(12'h004, 32'd9);
    apb_wr(12'h000, 32'h1);
    idle(3);
    apb_wr(12'h004, 32'd2);
    apb_rd(12'h014, d); chk("pend1_set", d & 32'h1, 1);
    idle(25);
    apb_rd(12'h014, d); chk("pend1_clr", d & 32'h1, 0);
    // aligned start with SYNC
    apb_wr(12'h000, 32'h0);
    apb_wr(12'h004, 32'd4);
    apb_wr(12'h008, 32'd6);
    apb_wr(12'h000, 32'h7);
    apb_rd(12'h000, d); chk("ctrl_rd", d, 3);
    idle(20);
    // unmapped and read-only offsets, upper DIV bits discarded
    apb_rd(12'h018, d); chk("unmapped_018", d, 0);
    apb_rd(12'hFFC, d); chk("unmapped_ffc", d, 0);
    apb_wr(12'h00C, 32'h55);
    apb_wr(12'h018, 32'hFFFF_FFFF);
    idle(10);
    apb_wr(12'h008, 32'hABCD_0005);
    apb_rd(12'h008, d); chk("div2_mask", d, 5);
    // asynchronous reset while a pulse is high
    apb_wr(12'h000, 32'h0);
    apb_wr(12'h004, 32'd0);
    apb_wr(12'h000, 32'h1);
    chk("tick1_hi", {31'b0, tclk1}, 1);
    prst = 1;
    #1;
    chk("async_tick1", {31'b0, tclk1}, 0);
    chk("async_prdata", prdata, 0);
    model_reset();
    step();
    prst = 0;
    idle(6);
    apb_rd(12'h000, d); chk("post_rst_ctrl", d, 0);
    apb_rd(12'h004, d); chk("post_rst_div1", d, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 9: idle($urandom_range(1, 4));
        2: apb_wr(12'h000, $urandom_range(0, 3) | (($urandom_range(0, 4) == 0) ? 32'h4 : 32'h0));
        3: apb_wr(12'h004, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 12));
        4: apb_wr(12'h008, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 12));
        5, 6, 7: apb_rd(offs[$urandom_range(0, 7)], d);
        default: apb_wr(offs[$urandom_range(3, 7)], $urandom);
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
